readout_sequencer: RTL

//   Sequences the per-channel readout after the SPI readout instruction. Steps

---
 rtl/psec_readout_pkg.sv | 16 +
 rtl/chan_next_finder.sv | 26 ++
 rtl/readout_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/psec_readout_pkg.sv
// rtl/psec_readout_pkg.sv - shared types and defaults for the readout sequencer
package psec_readout_pkg;

    localparam int DEF_NUM_CH = 8;
    localparam int SEL_W      = $clog2(DEF_NUM_CH);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        LOAD,
        WAIT,
        GAP,
        DONE
    } rdo_state_t;

endpackage

// File: rtl/chan_next_finder.sv
// rtl/chan_next_finder.sv - lowest enabled channel at or above a start index
module chan_next_finder
    import psec_readout_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [CH_W-1:0]   idx_i,
    output logic              found_o,
    output logic [CH_W-1:0]   next_idx_o
);

    // Scan from the top down so the last hit written is the lowest qualifying bit.
    always_comb begin
        found_o    = 1'b0;
        next_idx_o = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i] && (i >= int'(idx_i))) begin
                found_o    = 1'b1;
                next_idx_o = CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/readout_sequencer.sv
// rtl/readout_sequencer.sv - steps the serializer through the enabled readout channels
module readout_sequencer
    import psec_readout_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int WORDS_PER_CH = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int TIMEOUT      = 1023
) (
    input  logic                      iclk,
    input  logic                      rstn,
    input  logic                      readout_req,
    input  logic                      abort,
    input  logic [NUM_CH-1:0]         chan_mask,
    input  logic                      ser_word_done,
    output logic [$clog2(NUM_CH)-1:0] select_reg,
    output logic                      load_pulse,
    output logic                      busy,
    output logic                      readout_done,
    output logic                      req_dropped,
    output logic                      timeout_err
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int WC_W  = $clog2(WORDS_PER_CH + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    rdo_state_t        state_q, state_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [CH_W-1:0]   idx_q, idx_d;
    logic [CH_W-1:0]   sel_q, sel_d;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              load_q, load_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;
    logic              terr_q, terr_d;

    logic              found;
    logic [CH_W-1:0]   next_idx;
    logic              chan_end;
    logic              advance;

    chan_next_finder #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_finder (
        .mask_i     (mask_q),
        .idx_i      (idx_q),
        .found_o    (found),
        .next_idx_o (next_idx)
    );

    // Next-state and registered-output decode; abort overrides everything last.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        idx_d      = idx_q;
        sel_d      = sel_q;
        word_cnt_d = word_cnt_q;
        to_cnt_d   = to_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        terr_d     = terr_q;
        load_d     = 1'b0;
        done_d     = 1'b0;
        drop_d     = readout_req && (state_q != IDLE);
        chan_end   = 1'b0;
        advance    = 1'b0;

        case (state_q)
            IDLE: begin
                if (readout_req) begin
                    mask_d  = chan_mask;
                    terr_d  = 1'b0;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (found) begin
                    sel_d   = next_idx;
                    load_d  = 1'b1;
                    state_d = LOAD;
                end else begin
                    state_d = DONE;
                end
            end
            LOAD: begin
                word_cnt_d = '0;
                to_cnt_d   = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (ser_word_done) begin
                    to_cnt_d   = '0;
                    word_cnt_d = word_cnt_q + WC_W'(1);
                    chan_end   = (word_cnt_q == WC_W'(WORDS_PER_CH - 1));
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    terr_d   = 1'b1;
                    chan_end = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
                if (chan_end) begin
                    if (GAP_CYCLES == 0) begin
                        advance = 1'b1;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    advance = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Leaving a channel: scan upward from the next index; never wrap past the top.
        if (advance) begin
            if (sel_q == CH_W'(NUM_CH - 1)) begin
                state_d = DONE;
            end else begin
                idx_d   = sel_q + CH_W'(1);
                state_d = SCAN;
            end
        end

        busy_d = (state_d != IDLE);

        if (abort) begin
            state_d = IDLE;
            sel_d   = '0;
            load_d  = 1'b0;
            done_d  = 1'b0;
            busy_d  = 1'b0;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            idx_q      <= '0;
            sel_q      <= '0;
            word_cnt_q <= '0;
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            idx_q      <= idx_d;
            sel_q      <= sel_d;
            word_cnt_q <= word_cnt_d;
            to_cnt_q   <= to_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            load_q     <= load_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
            terr_q     <= terr_d;
        end
    end

    assign select_reg   = sel_q;
    assign load_pulse   = load_q;
    assign busy         = busy_q;
    assign readout_done = done_q;
    assign req_dropped  = drop_q;
    assign timeout_err  = terr_q;

endmodule
